ppg_frame_buffer: RTL and testbench
===================================

PPG_FRAME_BUFFER -- requirements
Module: ppg_frame_buffer

Interface
REQ-001 Parameter N, default 150, samples per frame; legal range 2..1024.
REQ-002 Parameter W, default 16, sample width in bits.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 sample_in  input  W  one PPG sample from the ADC front end.
REQ-006 sample_valid  input  1  single-cycle strobe; sample_in is valid in that cycle; it cannot be stalled.
REQ-007 frame_out  output  W*N  flattened frame; sample k at bits [k*W +: W]; k=0 is the oldest sample.
REQ-008 frame_valid  output  1  frame_out holds a complete frame.
REQ-009 frame_ack  input  1  consumer has taken frame_out; sampled only while frame_valid=1.
REQ-010 overrun  output  1  sticky flag: at least one sample was dropped.
REQ-011 overrun_count  output  8  number of dropped samples, saturating at 255.
REQ-012 frame_count  output  16  completed frames written, wraps 65535->0.

Function
REQ-013 Storage SHALL be two banks (ping-pong) of N W-bit words, each with a full flag, plus write pointer wr_idx (0..N-1), write bank wr_bank and read bank rd_bank.
REQ-014 A sample is accepted when sample_valid=1 and full[wr_bank]=0: written to bank wr_bank at index wr_idx.
REQ-015 Accepted sample with wr_idx<N-1: wr_idx increments.
REQ-016 Accepted sample with wr_idx=N-1: full[wr_bank] set, wr_idx->0, wr_bank toggles, frame_count increments; all in the same edge.
REQ-017 sample_valid=1 with full[wr_bank]=1: sample dropped, no pointer change, overrun set, overrun_count increments unless already 255.
REQ-018 frame_valid SHALL equal full[rd_bank]; it rises in the cycle after the Nth sample's edge (1-cycle latency).
REQ-019 frame_out SHALL be driven from bank rd_bank and SHALL be stable for as long as frame_valid=1.
REQ-020 frame_ack=1 with frame_valid=1: full[rd_bank] cleared and rd_bank toggles at that edge; the next frame is exposed in the following cycle if already full.
REQ-021 frame_ack=1 with frame_valid=0: ignored.
REQ-022 Frame completion on one bank and ack on the other bank in the same cycle: both take effect; no sample lost.
REQ-023 Ack of bank B and an accepted sample into bank B cannot coincide, because the write side only writes non-full banks; a sample dropped in the ack cycle counts as overrun (the clear takes effect next edge).
REQ-024 Overrun flag and count SHALL clear only on reset.
REQ-025 Sample order within a frame SHALL be preserved exactly; no arithmetic is applied to sample values.

Reset
REQ-026 While reset=0: wr_idx=0, wr_bank=0, rd_bank=0, both full flags 0, frame_valid=0, overrun=0, overrun_count=0, frame_count=0.
REQ-027 Bank contents need not be reset; frame_out is don't-care while frame_valid=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame and any unacknowledged frames.

Structure
REQ-029 Shared package ppg_pkg SHALL hold sample width, default frame length and the overrun counter width.
REQ-030 One sub-module, ppg_frame_bank (N x W register bank with write-enable, write index and flattened read port), SHALL be instantiated twice.

Verification
REQ-031 N=4: write samples 1,2,3,4 -> frame_valid rises 1 cycle after the 4th strobe, frame_out = {4,3,2,1}, frame_count=1.
REQ-032 Back-to-back: write 8 samples 10..17 with no ack -> first frame {13,12,11,10} held; ack -> next cycle frame_out={17,16,15,14}, frame_valid stays 1.
REQ-033 Overrun: N=4, write 12 samples, no ack -> samples 9..12 dropped, overrun=1, overrun_count=4; after 300 further drops the count stays 255.
REQ-034 Simultaneous: ack of bank 0 on the same edge as the 4th sample of bank 1 -> both banks handled, frame_valid stays 1, bank 1 data presented, overrun=0.
REQ-035 Reset after 2 of 4 samples, then write 5,6,7,8 -> frame_out={8,7,6,5}, frame_count=1.
REQ-036 frame_ack pulsed while frame_valid=0 -> no state change; a later frame is still delivered correctly.

Source files
------------

// File: rtl/ppg_pkg.sv
// Shared widths and defaults for the PPG frame buffer and its register banks.
package ppg_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int FRAME_N_DEF = 150;
  localparam int OVR_CNT_W   = 8;
  localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/ppg_frame_bank.sv
// N x W register bank: single write port addressed by index, full-width flattened read port.
module ppg_frame_bank
  import ppg_pkg::*;
#(
  parameter int N = FRAME_N_DEF,
  parameter int W = SAMPLE_W
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] idx,
  input  logic [W-1:0]         wdata,
  output logic [N*W-1:0]       rdata
);

  logic [W-1:0] mem [N];

  // Contents are not reset; the full flags in the parent qualify them.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign rdata[k*W +: W] = mem[k];
  end

endmodule

// File: rtl/ppg_frame_buffer.sv
// Ping-pong frame buffer: collects N PPG samples per frame into alternating banks
// and holds each completed frame until the consumer acknowledges it.
module ppg_frame_buffer
  import ppg_pkg::*;
#(
  parameter int N = FRAME_N_DEF,
  parameter int W = SAMPLE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [W-1:0]           sample_in,
  input  logic                   sample_valid,
  output logic [W*N-1:0]         frame_out,
  output logic                   frame_valid,
  input  logic                   frame_ack,
  output logic                   overrun,
  output logic [OVR_CNT_W-1:0]   overrun_count,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] wr_idx;
  logic             wr_bank;
  logic             rd_bank;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             accept;
  logic             drop;
  logic             last;
  logic             ack;
  logic [N*W-1:0]   rdata0;
  logic [N*W-1:0]   rdata1;

  assign accept = sample_valid & ~full[wr_bank];
  assign drop   = sample_valid &  full[wr_bank];
  assign last   = (wr_idx == IDX_W'(N - 1));
  assign ack    = frame_ack & full[rd_bank];

  ppg_frame_bank #(.N(N), .W(W)) u_bank0 (
    .clk   (clk),
    .we    (accept & ~wr_bank),
    .idx   (wr_idx),
    .wdata (sample_in),
    .rdata (rdata0)
  );

  ppg_frame_bank #(.N(N), .W(W)) u_bank1 (
    .clk   (clk),
    .we    (accept & wr_bank),
    .idx   (wr_idx),
    .wdata (sample_in),
    .rdata (rdata1)
  );

  // Set and clear never target the same bank: the write side only fills a non-full bank.
  always_comb begin
    full_nxt = full;
    if (ack)            full_nxt[rd_bank] = 1'b0;
    if (accept && last) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx        <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      full          <= 2'b00;
      overrun       <= 1'b0;
      overrun_count <= '0;
      frame_count   <= '0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        if (last) begin
          wr_idx      <= '0;
          wr_bank     <= ~wr_bank;
          frame_count <= frame_count + 1'b1;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (ack) rd_bank <= ~rd_bank;
      if (drop) begin
        overrun <= 1'b1;
        if (overrun_count != '1) overrun_count <= overrun_count + 1'b1;
      end
    end
  end

  // The read bank is never written while full, so frame_out holds while frame_valid is high.
  assign frame_valid = full[rd_bank];
  assign frame_out   = rd_bank ? rdata1 : rdata0;

endmodule

// File: tb/tb_ppg_frame_buffer.sv
// Bench for ppg_frame_buffer (N=4, W=16): directed table, corner sequences, random vs queue model.
module tb_ppg_frame_buffer;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [W-1:0]   sample_in = '0;
  logic           sample_valid = 1'b0;
  logic [W*N-1:0] frame_out;
  logic           frame_valid;
  logic           frame_ack = 1'b0;
  logic           overrun;
  logic [7:0]     overrun_count;
  logic [15:0]    frame_count;

  int n_tests = 0;
  int n_fail  = 0;

  ppg_frame_buffer #(.N(N), .W(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .frame_out     (frame_out),
    .frame_valid   (frame_valid),
    .frame_ack     (frame_ack),
    .overrun       (overrun),
    .overrun_count (overrun_count),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  // Reference model: completed frames awaiting ack, plus the frame being assembled.
  logic [W*N-1:0] m_pend [$];
  logic [W-1:0]   m_part [$];
  int             m_fc, m_ocnt;
  bit             m_ovr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_part.delete();
    m_fc = 0; m_ocnt = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit v, input logic [W-1:0] d, input bit a);
    int  pending;
    logic [W*N-1:0] f;
    pending = m_pend.size();
    if (a && pending > 0) void'(m_pend.pop_front());
    if (v && pending < 2) begin
      m_part.push_back(d);
      if (m_part.size() == N) begin
        for (int k = 0; k < N; k++) f[k*W +: W] = m_part[k];
        m_pend.push_back(f);
        m_part.delete();
        m_fc = (m_fc + 1) % 65536;
      end
    end else if (v) begin
      m_ovr = 1;
      if (m_ocnt < 255) m_ocnt++;
    end
  endtask

  task automatic model_check();
    chk("frame_valid", 64'(frame_valid), 64'(m_pend.size() > 0));
    if (m_pend.size() > 0) chk("frame_out", 64'(frame_out), 64'(m_pend[0]));
    chk("frame_count", 64'(frame_count), 64'(m_fc));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("overrun_count", 64'(overrun_count), 64'(m_ocnt));
  endtask

  // One clock: drive inputs, advance model, compare #1 after the edge.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit a);
    sample_valid = v;
    sample_in    = d;
    frame_ack    = a;
    model_step(v, d, a);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    frame_ack    = 1'b0;
    model_check();
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    frame_ack    = 1'b0;
    reset        = 1'b0;
    #2;
    chk("rst_frame_valid", 64'(frame_valid), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_overrun", 64'({overrun, overrun_count}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit             v;
    logic [W-1:0]   d;
    bit             a;
    bit             exp_fv;
    logic [W*N-1:0] exp_frame;
    int             exp_fc;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(bit v, int d, bit a, bit fv, logic [63:0] fr, int fc);
    vec_t r;
    r.v = v; r.d = W'(d); r.a = a; r.exp_fv = fv; r.exp_frame = fr; r.exp_fc = fc;
    return r;
  endfunction

  initial begin
    model_reset();
    vecs.push_back(mk(1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4, 0, 1, 64'h0004_0003_0002_0001, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1));
    for (int i = 10; i <= 12; i++) vecs.push_back(mk(1, i, 0, 0, 0, 1));
    vecs.push_back(mk(1, 13, 0, 1, 64'h000d_000c_000b_000a, 2));
    for (int i = 14; i <= 16; i++) vecs.push_back(mk(1, i, 0, 1, 64'h000d_000c_000b_000a, 2));
    vecs.push_back(mk(1, 17, 0, 1, 64'h000d_000c_000b_000a, 3));
    vecs.push_back(mk(0, 0, 1, 1, 64'h0011_0010_000f_000e, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 3));

    do_reset();
    foreach (vecs[i]) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].a);
      chk("tbl_fv", 64'(frame_valid), 64'(vecs[i].exp_fv));
      if (vecs[i].exp_fv) chk("tbl_frame", 64'(frame_out), 64'(vecs[i].exp_frame));
      chk("tbl_fc", 64'(frame_count), 64'(vecs[i].exp_fc));
    end

    // Overrun: third frame dropped, then saturation.
    do_reset();
    for (int i = 1; i <= 12; i++) cycle(1, W'(i), 0);
    chk("ovr_flag", 64'(overrun), 64'd1);
    chk("ovr_cnt4", 64'(overrun_count), 64'd4);
    chk("ovr_frame", 64'(frame_out), 64'h0004_0003_0002_0001);
    for (int i = 0; i < 300; i++) cycle(1, W'(i), 0);
    chk("ovr_sat", 64'(overrun_count), 64'd255);
    cycle(0, 0, 1);
    chk("ovr_after_ack", 64'(frame_out), 64'h0008_0007_0006_0005);
    chk("ovr_sticky", 64'(overrun), 64'd1);

    // Ack of bank 0 coinciding with the last sample of bank 1.
    do_reset();
    for (int i = 1; i <= 7; i++) cycle(1, W'(i), 0);
    cycle(1, 16'd8, 1);
    chk("sim_fv", 64'(frame_valid), 64'd1);
    chk("sim_frame", 64'(frame_out), 64'h0008_0007_0006_0005);
    chk("sim_ovr", 64'(overrun), 64'd0);
    chk("sim_fc", 64'(frame_count), 64'd2);

    // Drop during the ack cycle still counts as overrun.
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1, W'(i), 0);
    cycle(1, 16'd99, 1);
    chk("ackdrop_cnt", 64'(overrun_count), 64'd1);
    cycle(1, 16'd20, 0);
    chk("ackdrop_accept", 64'(overrun_count), 64'd1);

    // Reset mid-frame discards the partial frame.
    do_reset();
    cycle(1, 16'd1, 0);
    cycle(1, 16'd2, 0);
    do_reset();
    for (int i = 5; i <= 8; i++) cycle(1, W'(i), 0);
    chk("rst_mid_frame", 64'(frame_out), 64'h0008_0007_0006_0005);
    chk("rst_mid_fc", 64'(frame_count), 64'd1);

    // Spurious acks while no frame is valid.
    do_reset();
    cycle(0, 0, 1);
    cycle(1, 16'h21, 1);
    cycle(1, 16'h22, 1);
    cycle(1, 16'h23, 0);
    cycle(1, 16'h24, 0);
    chk("spur_frame", 64'(frame_out), 64'h0024_0023_0022_0021);
    chk("spur_fv", 64'(frame_valid), 64'd1);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle($urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 9) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
